logic_op_sequencer: RTL and testbench

- Multi-cycle controller that sequences one logical-class instruction (AND/OR/NAND/NOR) through the shared 8-bit logical unit.
- Accepts an instruction over a valid/ready handshake and reads both operands through the single register-file read port. It then drives the logical unit and writes the result back.
- Sits between the instruction decoder/issue stage and the register file; owns the logical unit's inputs.

---
 rtl/logic_seq_pkg.sv | 30 +++
 rtl/logic_op_sequencer_if.sv | 46 ++++
 rtl/logic_op_decode.sv | 24 ++
 rtl/logic_op_sequencer.sv | 154 +++++++++++++++
 tb/tb_logic_op_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_seq_pkg.sv
// Shared definitions for the class sequencers that drive the 8-bit logical unit.
// Contents:
//   - default widths
//   - logical-class mode and sub-field encodings
//   - logical-unit opcode enum
//   - sequencer state enum
package logic_seq_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int REG_ADDR_WIDTH_DEF = 2;

    localparam logic [1:0] MODE_LOGIC     = 2'b01;
    localparam logic [2:0] SUBFIELD_LOGIC = 3'b000;

    typedef enum logic [2:0] {
        LU_AND  = 3'b000,
        LU_OR   = 3'b001,
        LU_NAND = 3'b010,
        LU_NOR  = 3'b011
    } lu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_EXECUTE,
        S_WRITEBACK
    } state_e;

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Bundle of every non-clock signal around the logic-op sequencer.
// Groups:
//   - issue handshake: instValid, instReady, instruction, regA/regB/regDest, abort
//   - register-file port: rfRead*, rfWrite*
//   - logical-unit port: luOpcode, luOperandA/B, luResult
//   - status: done, illegalOp, zeroFlag
// Modports:
//   - master: the sequencer itself
//   - slave: its surroundings (issue stage, register file, logical unit)
interface logic_op_sequencer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 2
);
    logic                      instValid;
    logic                      instReady;
    logic [7:0]                instruction;
    logic [REG_ADDR_WIDTH-1:0] regA;
    logic [REG_ADDR_WIDTH-1:0] regB;
    logic [REG_ADDR_WIDTH-1:0] regDest;
    logic                      abort;
    logic [REG_ADDR_WIDTH-1:0] rfReadAddr;
    logic [DATA_WIDTH-1:0]     rfReadData;
    logic                      rfWriteEnable;
    logic [REG_ADDR_WIDTH-1:0] rfWriteAddr;
    logic [DATA_WIDTH-1:0]     rfWriteData;
    logic [2:0]                luOpcode;
    logic [DATA_WIDTH-1:0]     luOperandA;
    logic [DATA_WIDTH-1:0]     luOperandB;
    logic [DATA_WIDTH-1:0]     luResult;
    logic                      done;
    logic                      illegalOp;
    logic                      zeroFlag;

    modport master (
        input  instValid, instruction, regA, regB, regDest, abort, rfReadData, luResult,
        output instReady, rfReadAddr, rfWriteEnable, rfWriteAddr, rfWriteData,
               luOpcode, luOperandA, luOperandB, done, illegalOp, zeroFlag
    );

    modport slave (
        output instValid, instruction, regA, regB, regDest, abort, rfReadData, luResult,
        input  instReady, rfReadAddr, rfWriteEnable, rfWriteAddr, rfWriteData,
               luOpcode, luOperandA, luOperandB, done, illegalOp, zeroFlag
    );

endinterface

// File: rtl/logic_op_decode.sv
// Combinational decode of a logical-class instruction.
// Ports:
//   - instruction: raw 8-bit encoding
//   - legal: mode 01, sub-field 000, op in AND..NOR
//   - opcode: logical-unit opcode; AND when the instruction is illegal
module logic_op_decode
    import logic_seq_pkg::*;
(
    input  logic [7:0] instruction,
    output logic       legal,
    output lu_op_e     opcode
);

    always_comb begin
        legal  = (instruction[7:6] == MODE_LOGIC) &&
                 (instruction[5:3] == SUBFIELD_LOGIC) &&
                 !instruction[2];
        opcode = LU_AND;
        if (legal) begin
            opcode = lu_op_e'(instruction[2:0]);
        end
    end

endmodule

// File: rtl/logic_op_sequencer.sv
// Sequences one AND/OR/NAND/NOR instruction through the shared logical unit.
// Flow: read A, read B (skipped when regA == regB), execute, write back.
// Ports:
//   - clock: rising-edge system clock
//   - reset: asynchronous, active-high
//   - bus: issue handshake, register-file port, logical-unit port and status
//
// state       | meaning
// S_IDLE      | ready for an instruction; an illegal one retires here a cycle later
// S_FETCH_A   | read regA into opA (and opB when regA == regB)
// S_FETCH_B   | read regB into opB
// S_EXECUTE   | capture the logical-unit result
// S_WRITEBACK | write the result, pulse done, update zeroFlag
module logic_op_sequencer
    import logic_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input logic                clock,
    input logic                reset,
    logic_op_sequencer_if.master bus
);

    state_e                    state, next_state;
    lu_op_e                    op_q;
    logic [REG_ADDR_WIDTH-1:0] rega_q, regb_q, regdest_q;
    logic [DATA_WIDTH-1:0]     opa_q, opb_q, result_q;
    logic                      zero_q;
    logic                      illegal_q;

    logic                      dec_legal;
    lu_op_e                    dec_op;
    logic                      accept;

    logic                      inst_ready;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      wr_en;
    logic [REG_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      done_c;
    logic                      illegal_c;

    logic_op_decode u_decode (
        .instruction (bus.instruction),
        .legal       (dec_legal),
        .opcode      (dec_op)
    );

    // Accept is formed from state directly rather than from instReady so the
    // handshake stays free of a combinational path through the output port.
    assign accept = bus.instValid && (state == S_IDLE) && !bus.abort;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        inst_ready = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        // An illegal instruction retires in the cycle after its accept, in IDLE.
        done_c     = illegal_q;
        illegal_c  = illegal_q;
        case (state)
            S_IDLE: begin
                inst_ready = !bus.abort;
                if (accept && dec_legal) begin
                    next_state = S_FETCH_A;
                end
            end
            S_FETCH_A: begin
                rd_addr = rega_q;
                if (bus.abort) begin
                    next_state = S_IDLE;
                end else if (rega_q == regb_q) begin
                    next_state = S_EXECUTE;
                end else begin
                    next_state = S_FETCH_B;
                end
            end
            S_FETCH_B: begin
                rd_addr    = regb_q;
                next_state = bus.abort ? S_IDLE : S_EXECUTE;
            end
            S_EXECUTE: begin
                next_state = bus.abort ? S_IDLE : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                wr_en      = 1'b1;
                wr_addr    = regdest_q;
                wr_data    = result_q;
                done_c     = 1'b1;
                illegal_c  = 1'b0;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q      <= LU_AND;
            rega_q    <= '0;
            regb_q    <= '0;
            regdest_q <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !dec_legal;
            if (accept) begin
                op_q      <= dec_op;
                rega_q    <= bus.regA;
                regb_q    <= bus.regB;
                regdest_q <= bus.regDest;
            end
            case (state)
                S_FETCH_A: begin
                    opa_q <= bus.rfReadData;
                    if (rega_q == regb_q) begin
                        opb_q <= bus.rfReadData;
                    end
                end
                S_FETCH_B:   opb_q    <= bus.rfReadData;
                S_EXECUTE:   result_q <= bus.luResult;
                S_WRITEBACK: zero_q   <= (result_q == '0);
                default: ;
            endcase
        end
    end

    assign bus.instReady     = inst_ready;
    assign bus.rfReadAddr    = rd_addr;
    assign bus.rfWriteEnable = wr_en;
    assign bus.rfWriteAddr   = wr_addr;
    assign bus.rfWriteData   = wr_data;
    assign bus.luOpcode      = op_q;
    assign bus.luOperandA    = opa_q;
    assign bus.luOperandB    = opb_q;
    assign bus.done          = done_c;
    assign bus.illegalOp     = illegal_c;
    assign bus.zeroFlag      = zero_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
module tb_logic_op_sequencer;
    import logic_seq_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic_op_sequencer_if #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(2)) bus ();

    logic_op_sequencer #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    logic [7:0] rf [4];
    logic       pre_we = 1'b0;
    logic [1:0] pre_addr = 2'd0;
    logic [7:0] pre_data = 8'd0;

    int         cyc = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         rd2_cnt = 0;
    int         done_cyc = 0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       done_ill = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic logic [7:0] lu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    // Register file and logical unit surrounding the sequencer.
    assign bus.rfReadData = rf[bus.rfReadAddr];
    assign bus.luResult   = lu_ref(bus.luOpcode, bus.luOperandA, bus.luOperandB);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.rfWriteEnable) rf[bus.rfWriteAddr] <= bus.rfWriteData;
        else if (pre_we)       rf[pre_addr] <= pre_data;
    end

    always @(negedge clock) begin
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_ill = bus.illegalOp;
        end
        if (bus.rfWriteEnable) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = bus.rfWriteAddr;
            wr_data = bus.rfWriteData;
        end
        if (bus.rfReadAddr == 2'd2) rd2_cnt = rd2_cnt + 1;
    end

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic start(input logic [7:0] instr, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input bit push, output int t_acc);
        exp_t e;
        @(negedge clock);
        bus.instValid = 1'b1; bus.instruction = instr;
        bus.regA = a; bus.regB = b; bus.regDest = d;
        if (push) begin
            e.addr = d;
            e.data = lu_ref(instr[2:0], rf[a], rf[b]);
            sb.push_back(e);
        end
        t_acc = cyc;
        @(posedge clock);
        #1 bus.instValid = 1'b0;
    endtask

    task automatic wait_done(input int base_done, output bit to);
        to = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            #1;
            if (done_cnt != base_done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        total_cnt++; if (bus.instReady !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.instReady); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.rfWriteEnable !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.rfWriteEnable); else pass_cnt++;
        total_cnt++; if (bus.luOpcode !== 3'd0) $display("FAIL reset_luop: got %0d want 0", bus.luOpcode); else pass_cnt++;
        total_cnt++; if (bus.luOperandA !== 8'h00) $display("FAIL reset_opa: got %h want 00", bus.luOperandA); else pass_cnt++;
        total_cnt++; if (bus.zeroFlag !== 1'b0) $display("FAIL reset_zero: got %b want 0", bus.zeroFlag); else pass_cnt++;
    endtask

    task automatic test_and;
        int t, bd, bw; bit to; exp_t e;
        preload(2'd1, 8'hF0); preload(2'd2, 8'h3C);
        bd = done_cnt; bw = wr_cnt;
        start(8'h40, 2'd1, 2'd2, 2'd3, 1'b1, t);
        wait_done(bd, to);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        total_cnt++; if (to) $display("FAIL and_timeout: no done within budget"); else pass_cnt++;
        total_cnt++; if (done_cyc - t !== 4) $display("FAIL and_latency: got %0d want 4", done_cyc - t); else pass_cnt++;
        total_cnt++; if (wr_cnt - bw !== 1) $display("FAIL and_writes: got %0d want 1", wr_cnt - bw); else pass_cnt++;
        total_cnt++; if (wr_addr !== e.addr) $display("FAIL and_addr: got %0d want %0d", wr_addr, e.addr); else pass_cnt++;
        total_cnt++; if (wr_data !== e.data) $display("FAIL and_data: got %h want %h", wr_data, e.data); else pass_cnt++;
        total_cnt++; if (done_ill !== 1'b0) $display("FAIL and_illegal: got %b want 0", done_ill); else pass_cnt++;
        @(negedge clock); #1;
        total_cnt++; if (bus.zeroFlag !== 1'b0) $display("FAIL and_zero: got %b want 0", bus.zeroFlag); else pass_cnt++;
    endtask

    task automatic test_nor_or;
        int t, bd; bit to; exp_t e;
        preload(2'd0, 8'h0F); preload(2'd1, 8'hF0);
        bd = done_cnt;
        start(8'h43, 2'd0, 2'd1, 2'd3, 1'b1, t);
        wait_done(bd, to);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        total_cnt++; if (wr_data !== e.data) $display("FAIL nor_data: got %h want %h", wr_data, e.data); else pass_cnt++;
        @(negedge clock); #1;
        total_cnt++; if (bus.zeroFlag !== 1'b1) $display("FAIL nor_zero: got %b want 1", bus.zeroFlag); else pass_cnt++;
        bd = done_cnt;
        start(8'h41, 2'd0, 2'd1, 2'd3, 1'b1, t);
        wait_done(bd, to);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        total_cnt++; if (to) $display("FAIL or_timeout: no done within budget"); else pass_cnt++;
        total_cnt++; if (wr_data !== e.data) $display("FAIL or_data: got %h want %h", wr_data, e.data); else pass_cnt++;
        @(negedge clock); #1;
        total_cnt++; if (bus.zeroFlag !== 1'b0) $display("FAIL or_zero: got %b want 0", bus.zeroFlag); else pass_cnt++;
    endtask

    task automatic test_same_reg;
        int t, bd, br; bit to; exp_t e;
        preload(2'd2, 8'hA5);
        bd = done_cnt; br = rd2_cnt;
        start(8'h42, 2'd2, 2'd2, 2'd0, 1'b1, t);
        wait_done(bd, to);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        total_cnt++; if (done_cyc - t !== 3) $display("FAIL same_latency: got %0d want 3", done_cyc - t); else pass_cnt++;
        total_cnt++; if (wr_data !== e.data) $display("FAIL same_data: got %h want %h", wr_data, e.data); else pass_cnt++;
        total_cnt++; if (wr_addr !== e.addr) $display("FAIL same_addr: got %0d want %0d", wr_addr, e.addr); else pass_cnt++;
        total_cnt++; if (rd2_cnt - br !== 1) $display("FAIL same_reads: got %0d want 1", rd2_cnt - br); else pass_cnt++;
    endtask

    task automatic test_illegal_back_to_back;
        int t, bd, bw; bit to; exp_t e;
        bd = done_cnt; bw = wr_cnt;
        @(negedge clock);
        bus.instValid = 1'b1; bus.instruction = 8'h44;
        bus.regA = 2'd1; bus.regB = 2'd2; bus.regDest = 2'd3;
        @(posedge clock);
        #1;
        bus.instruction = 8'h40;
        e.addr = 2'd3; e.data = lu_ref(3'd0, rf[1], rf[2]);
        sb.push_back(e);
        @(negedge clock);
        total_cnt++; if (bus.done !== 1'b1) $display("FAIL ill_done: got %b want 1", bus.done); else pass_cnt++;
        total_cnt++; if (bus.illegalOp !== 1'b1) $display("FAIL ill_flag: got %b want 1", bus.illegalOp); else pass_cnt++;
        total_cnt++; if (bus.instReady !== 1'b1) $display("FAIL ill_ready: got %b want 1", bus.instReady); else pass_cnt++;
        t = cyc;
        @(posedge clock);
        #1 bus.instValid = 1'b0;
        wait_done(bd + 1, to);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        total_cnt++; if (done_cyc - t !== 4) $display("FAIL b2b_latency: got %0d want 4", done_cyc - t); else pass_cnt++;
        total_cnt++; if (wr_cnt - bw !== 1) $display("FAIL b2b_writes: got %0d want 1", wr_cnt - bw); else pass_cnt++;
        total_cnt++; if (wr_data !== e.data) $display("FAIL b2b_data: got %h want %h", wr_data, e.data); else pass_cnt++;
        total_cnt++; if (done_ill !== 1'b0) $display("FAIL b2b_illegal: got %b want 0", done_ill); else pass_cnt++;
        @(negedge clock); #1;
        bd = done_cnt; bw = wr_cnt;
        start(8'h80, 2'd0, 2'd1, 2'd2, 1'b0, t);
        wait_done(bd, to);
        total_cnt++; if (done_cyc - t !== 1) $display("FAIL mode_latency: got %0d want 1", done_cyc - t); else pass_cnt++;
        total_cnt++; if (done_ill !== 1'b1) $display("FAIL mode_illegal: got %b want 1", done_ill); else pass_cnt++;
        total_cnt++; if (wr_cnt - bw !== 0) $display("FAIL mode_writes: got %0d want 0", wr_cnt - bw); else pass_cnt++;
    endtask

    task automatic test_abort;
        int t, bd, bw; bit to; exp_t e;
        bd = done_cnt; bw = wr_cnt;
        start(8'h40, 2'd1, 2'd2, 2'd0, 1'b0, t);
        @(posedge clock); @(posedge clock);
        #1 bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        @(negedge clock);
        total_cnt++; if (bus.instReady !== 1'b1) $display("FAIL abort_ready: got %b want 1", bus.instReady); else pass_cnt++;
        bus.abort = 1'b1; bus.instValid = 1'b1; bus.instruction = 8'h41;
        #1;
        total_cnt++; if (bus.instReady !== 1'b0) $display("FAIL abort_idle_ready: got %b want 0", bus.instReady); else pass_cnt++;
        @(posedge clock);
        #1 bus.abort = 1'b0; bus.instValid = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        total_cnt++; if (wr_cnt - bw !== 0) $display("FAIL abort_writes: got %0d want 0", wr_cnt - bw); else pass_cnt++;
        total_cnt++; if (done_cnt - bd !== 0) $display("FAIL abort_dones: got %0d want 0", done_cnt - bd); else pass_cnt++;
        bd = done_cnt; bw = wr_cnt;
        start(8'h41, 2'd1, 2'd2, 2'd0, 1'b1, t);
        @(posedge clock); @(posedge clock); @(posedge clock);
        #1 bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        wait_done(bd, to);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        total_cnt++; if (wr_cnt - bw !== 1) $display("FAIL wbabort_writes: got %0d want 1", wr_cnt - bw); else pass_cnt++;
        total_cnt++; if (wr_data !== e.data) $display("FAIL wbabort_data: got %h want %h", wr_data, e.data); else pass_cnt++;
        total_cnt++; if (done_cyc - t !== 4) $display("FAIL wbabort_latency: got %0d want 4", done_cyc - t); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        int t, bd, bw; bit to; exp_t e;
        bd = done_cnt; bw = wr_cnt;
        start(8'h40, 2'd1, 2'd2, 2'd3, 1'b0, t);
        @(posedge clock);
        #1;
        total_cnt++; if (bus.rfReadAddr !== 2'd2) $display("FAIL rst_fetchb_addr: got %0d want 2", bus.rfReadAddr); else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total_cnt++; if (bus.rfReadAddr !== 2'd0) $display("FAIL rst_rdaddr: got %0d want 0", bus.rfReadAddr); else pass_cnt++;
        total_cnt++; if (bus.luOperandA !== 8'h00) $display("FAIL rst_opa: got %h want 00", bus.luOperandA); else pass_cnt++;
        total_cnt++; if (bus.instReady !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.instReady); else pass_cnt++;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        total_cnt++; if (wr_cnt - bw !== 0) $display("FAIL rst_writes: got %0d want 0", wr_cnt - bw); else pass_cnt++;
        total_cnt++; if (done_cnt - bd !== 0) $display("FAIL rst_dones: got %0d want 0", done_cnt - bd); else pass_cnt++;
        bd = done_cnt;
        start(8'h40, 2'd1, 2'd2, 2'd3, 1'b1, t);
        wait_done(bd, to);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        total_cnt++; if (done_cyc - t !== 4) $display("FAIL postrst_latency: got %0d want 4", done_cyc - t); else pass_cnt++;
        total_cnt++; if (wr_data !== e.data) $display("FAIL postrst_data: got %h want %h", wr_data, e.data); else pass_cnt++;
        total_cnt++; if (sb.size() !== 0) $display("FAIL sb_drain: got %0d entries want 0", sb.size()); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        bus.instValid = 1'b0; bus.instruction = 8'h00;
        bus.regA = 2'd0; bus.regB = 2'd0; bus.regDest = 2'd0; bus.abort = 1'b0;
        preload(2'd0, 8'h11); preload(2'd1, 8'h22);
        preload(2'd2, 8'h33); preload(2'd3, 8'h44);
        #1;
        test_reset;
        @(negedge clock);
        reset = 1'b0;
        test_and;
        test_nor_or;
        test_same_reg;
        test_illegal_back_to_back;
        test_abort;
        test_async_reset;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
